lms_seq_ctrl: RTL and testbench

LMS_SEQ_CTRL -- requirements
Module: lms_seq_ctrl

---
 rtl/lms_pkg.sv | 26 ++
 rtl/lms_seq_ctrl_if.sv | 33 +++
 rtl/lms_tap_addr_gen.sv | 44 ++++
 rtl/lms_seq_ctrl.sv | 175 +++++++++++++++++
 tb/tb_lms_seq_ctrl.sv | 247 ++++++++++++++++++++++++
 5 files changed

// File: rtl/lms_pkg.sv
// Shared types and defaults for the LMS sequencing controller.
package lms_pkg;

   typedef enum logic [2:0] {
      StIdle,
      StWrite,
      StFilt,
      StErr,
      StUpd,
      StClr
   } lms_state_e;

   localparam int unsigned LmsTapDefault  = 63;
   localparam int unsigned LmsDatWDefault = 16;

   // Smallest address width able to index 'tap' entries (minimum 1 bit).
   function automatic int unsigned lms_addr_w(int unsigned tap);
      int unsigned w;
      w = 1;
      while ((32'd1 << w) < tap) begin
         w++;
      end
      return w;
   endfunction

endpackage

// File: rtl/lms_seq_ctrl_if.sv
// Handshake and control bundle between the LMS sequencer and its datapath.
interface lms_seq_ctrl_if #(
   parameter int unsigned ADDR_W = 6
);
   logic              inValid;
   logic              inReady;
   logic              adaptEn;
   logic              flush;
   logic [ADDR_W-1:0] tapAddr;
   logic              dlWrEn;
   logic [ADDR_W-1:0] wrPtr;
   logic              macClr;
   logic              macEn;
   logic              errLatch;
   logic              coefWrEn;
   logic              coefClr;
   logic              outValid;
   logic              busy;

   // Sample source / datapath side.
   modport master (
      output inValid, adaptEn, flush,
      input  inReady, tapAddr, dlWrEn, wrPtr, macClr, macEn, errLatch,
             coefWrEn, coefClr, outValid, busy
   );

   // Controller side.
   modport slave (
      input  inValid, adaptEn, flush,
      output inReady, tapAddr, dlWrEn, wrPtr, macClr, macEn, errLatch,
             coefWrEn, coefClr, outValid, busy
   );
endinterface

// File: rtl/lms_tap_addr_gen.sv
// Loadable modulo-TAP up/down counter used for tap addresses and the delay-line head.
module lms_tap_addr_gen #(
   parameter int unsigned TAP    = 63,
   parameter int unsigned ADDR_W = 6
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              load_i,
   input  logic [ADDR_W-1:0] load_val_i,
   input  logic              en_i,
   input  logic              dn_i,
   output logic [ADDR_W-1:0] cnt_o
);

   localparam logic [ADDR_W-1:0] MaxVal = ADDR_W'(TAP - 1);

   logic [ADDR_W-1:0] cnt_q, cnt_d;

   // Load wins over stepping; both directions wrap inside 0..TAP-1.
   always_comb begin
      cnt_d = cnt_q;
      if (load_i) begin
         cnt_d = load_val_i;
      end else if (en_i) begin
         if (dn_i) begin
            cnt_d = (cnt_q == '0) ? MaxVal : cnt_q - 1'b1;
         end else begin
            cnt_d = (cnt_q >= MaxVal) ? '0 : cnt_q + 1'b1;
         end
      end
   end

   // Counter register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign cnt_o = cnt_q;

endmodule

// File: rtl/lms_seq_ctrl.sv
// Sequencer for an LMS adaptive FIR: delay-line write, filter pass, error
// capture, optional coefficient update and coefficient flush.
module lms_seq_ctrl
   import lms_pkg::*;
#(
   parameter int unsigned DAT_W  = LmsDatWDefault,
   parameter int unsigned TAP    = LmsTapDefault,
   parameter int unsigned ADDR_W = lms_addr_w(LmsTapDefault)
) (
   input logic           clk,
   input logic           rst,
   lms_seq_ctrl_if.slave ctrl_io
);

   if (DAT_W == 0 || TAP < 2 || TAP > 64 || (32'd1 << ADDR_W) < TAP) begin : g_bad_param
      $error("lms_seq_ctrl: illegal DAT_W/TAP/ADDR_W combination");
   end

   localparam logic [ADDR_W-1:0] LastIdx = ADDR_W'(TAP - 1);

   lms_state_e        state_q, state_d;
   logic [ADDR_W-1:0] k_q, k_d;
   logic              pend_q, pend_d;
   logic              adapt_q, adapt_d;

   logic in_ready_q, dl_wr_q, mac_en_q, mac_clr_q, err_q, coef_wr_q, coef_clr_q;

   logic              tap_ld, tap_en, tap_dn;
   logic [ADDR_W-1:0] tap_val, tap_addr;
   logic              wp_ld, wp_en;
   logic [ADDR_W-1:0] wr_ptr;

   // Next state plus the address counter controls for the following cycle.
   always_comb begin
      state_d = state_q;
      k_d     = k_q;
      pend_d  = pend_q | ctrl_io.flush;
      adapt_d = adapt_q;
      tap_ld  = 1'b0;
      tap_val = wr_ptr;
      tap_en  = 1'b0;
      tap_dn  = 1'b1;
      wp_ld   = 1'b0;
      wp_en   = 1'b0;
      unique case (state_q)
         StIdle: begin
            // A pending or fresh flush beats a sample offered in the same cycle.
            if (pend_q || ctrl_io.flush) begin
               state_d = StClr;
               k_d     = '0;
               pend_d  = 1'b0;
               tap_ld  = 1'b1;
               tap_val = '0;
            end else if (ctrl_io.inValid && in_ready_q) begin
               state_d = StWrite;
               adapt_d = ctrl_io.adaptEn;
               tap_ld  = 1'b1;
            end
         end
         StWrite: begin
            state_d = StFilt;
            k_d     = '0;
            tap_ld  = 1'b1;
         end
         StFilt: begin
            if (k_q == LastIdx) begin
               state_d = StErr;
            end else begin
               k_d    = k_q + 1'b1;
               tap_en = 1'b1;
            end
         end
         StErr: begin
            if (adapt_q) begin
               state_d = StUpd;
               k_d     = '0;
               tap_ld  = 1'b1;
            end else begin
               state_d = StIdle;
               wp_en   = 1'b1;
            end
         end
         StUpd: begin
            if (k_q == LastIdx) begin
               state_d = StIdle;
               wp_en   = 1'b1;
            end else begin
               k_d    = k_q + 1'b1;
               tap_en = 1'b1;
            end
         end
         StClr: begin
            if (k_q == LastIdx) begin
               state_d = StIdle;
               wp_ld   = 1'b1;
            end else begin
               k_d    = k_q + 1'b1;
               tap_en = 1'b1;
               tap_dn = 1'b0;
            end
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   // State, bookkeeping and registered control strobes decoded from the next state.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= StIdle;
         k_q        <= '0;
         pend_q     <= 1'b0;
         adapt_q    <= 1'b0;
         in_ready_q <= 1'b0;
         dl_wr_q    <= 1'b0;
         mac_en_q   <= 1'b0;
         mac_clr_q  <= 1'b0;
         err_q      <= 1'b0;
         coef_wr_q  <= 1'b0;
         coef_clr_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         k_q        <= k_d;
         pend_q     <= pend_d;
         adapt_q    <= adapt_d;
         in_ready_q <= (state_d == StIdle) && !pend_d;
         dl_wr_q    <= (state_d == StWrite);
         mac_en_q   <= (state_d == StFilt);
         mac_clr_q  <= (state_d == StFilt) && (k_d == '0);
         err_q      <= (state_d == StErr);
         coef_wr_q  <= (state_d == StUpd) || (state_d == StClr);
         coef_clr_q <= (state_d == StClr);
      end
   end

   lms_tap_addr_gen #(
      .TAP    (TAP),
      .ADDR_W (ADDR_W)
   ) u_tap_addr (
      .clk        (clk),
      .rst        (rst),
      .load_i     (tap_ld),
      .load_val_i (tap_val),
      .en_i       (tap_en),
      .dn_i       (tap_dn),
      .cnt_o      (tap_addr)
   );

   lms_tap_addr_gen #(
      .TAP    (TAP),
      .ADDR_W (ADDR_W)
   ) u_wr_ptr (
      .clk        (clk),
      .rst        (rst),
      .load_i     (wp_ld),
      .load_val_i ('0),
      .en_i       (wp_en),
      .dn_i       (1'b0),
      .cnt_o      (wr_ptr)
   );

   assign ctrl_io.inReady  = in_ready_q;
   assign ctrl_io.tapAddr  = tap_addr;
   assign ctrl_io.dlWrEn   = dl_wr_q;
   assign ctrl_io.wrPtr    = wr_ptr;
   assign ctrl_io.macClr   = mac_clr_q;
   assign ctrl_io.macEn    = mac_en_q;
   assign ctrl_io.errLatch = err_q;
   assign ctrl_io.coefWrEn = coef_wr_q;
   assign ctrl_io.coefClr  = coef_clr_q;
   assign ctrl_io.outValid = err_q;
   assign ctrl_io.busy     = (state_q != StIdle);

endmodule

// File: tb/tb_lms_seq_ctrl.sv
// Bench for lms_seq_ctrl: a TAP=63 and a TAP=4 instance share one stimulus
// stream; each is checked every cycle against a transaction-level schedule.
module tb_lms_seq_ctrl;

   // Flag vector: busy inReady dlWrEn macEn macClr errLatch outValid coefWrEn coefClr
   localparam logic [8:0] FlIdleRdy = 9'h080;
   localparam logic [8:0] FlIdle    = 9'h000;
   localparam logic [8:0] FlWrite   = 9'h140;
   localparam logic [8:0] FlFilt    = 9'h120;
   localparam logic [8:0] FlFiltClr = 9'h130;
   localparam logic [8:0] FlErr     = 9'h10C;
   localparam logic [8:0] FlUpd     = 9'h102;
   localparam logic [8:0] FlClr     = 9'h103;

   typedef struct packed {
      logic [8:0] flags;
      logic       chk_addr;
      logic [7:0] addr;
      logic [7:0] wp;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic inValid = 1'b0;
   logic adaptEn = 1'b0;
   logic flush = 1'b0;

   int n_chk = 0;
   int n_fail = 0;
   int cyc = 0;

   exp_t sched[2][$];
   int   wp_m[2];
   bit   pend_m[2];
   int   tap_m[2];

   always #5 clk = ~clk;

   lms_seq_ctrl_if #(.ADDR_W(6)) if0 ();
   lms_seq_ctrl_if #(.ADDR_W(2)) if1 ();

   assign if0.inValid = inValid;
   assign if0.adaptEn = adaptEn;
   assign if0.flush   = flush;
   assign if1.inValid = inValid;
   assign if1.adaptEn = adaptEn;
   assign if1.flush   = flush;

   lms_seq_ctrl #(.DAT_W(16), .TAP(63), .ADDR_W(6)) u_dut0 (
      .clk     (clk),
      .rst     (rst),
      .ctrl_io (if0)
   );

   lms_seq_ctrl #(.DAT_W(16), .TAP(4), .ADDR_W(2)) u_dut1 (
      .clk     (clk),
      .rst     (rst),
      .ctrl_io (if1)
   );

   function automatic logic [8:0] obs_flags(int d);
      if (d == 0) begin
         return {if0.busy, if0.inReady, if0.dlWrEn, if0.macEn, if0.macClr, if0.errLatch,
                 if0.outValid, if0.coefWrEn, if0.coefClr};
      end
      return {if1.busy, if1.inReady, if1.dlWrEn, if1.macEn, if1.macClr, if1.errLatch,
              if1.outValid, if1.coefWrEn, if1.coefClr};
   endfunction

   function automatic logic [7:0] obs_addr(int d);
      return (d == 0) ? 8'(if0.tapAddr) : 8'(if1.tapAddr);
   endfunction

   function automatic logic [7:0] obs_wp(int d);
      return (d == 0) ? 8'(if0.wrPtr) : 8'(if1.wrPtr);
   endfunction

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   function automatic void push(int d, logic [8:0] fl, bit ca, int addr, int wp);
      exp_t e;
      e.flags    = fl;
      e.chk_addr = ca;
      e.addr     = 8'(addr);
      e.wp       = 8'(wp);
      sched[d].push_back(e);
   endfunction

   // Idle-cycle decision: flush first, otherwise accept and lay out the whole sample.
   function automatic void model_decide(int d, bit v, bit a, bit f);
      int t;
      int w;
      t = tap_m[d];
      w = wp_m[d];
      if (pend_m[d] || f) begin
         for (int k = 0; k < t; k++) push(d, FlClr, 1'b1, k, w);
         wp_m[d]   = 0;
         pend_m[d] = 1'b0;
      end else if (v) begin
         push(d, FlWrite, 1'b1, w, w);
         for (int k = 0; k < t; k++) push(d, (k == 0) ? FlFiltClr : FlFilt, 1'b1, (w - k + t) % t, w);
         push(d, FlErr, 1'b0, 0, w);
         if (a) begin
            for (int k = 0; k < t; k++) push(d, FlUpd, 1'b1, (w - k + t) % t, w);
         end
         wp_m[d] = (w + 1) % t;
      end
   endfunction

   // Check the current cycle, then drive the inputs seen at the next rising edge.
   task automatic step(input bit v, input bit a, input bit f);
      @(negedge clk);
      cyc++;
      for (int d = 0; d < 2; d++) begin
         exp_t e;
         bit   idle;
         idle = (sched[d].size() == 0);
         if (idle) begin
            e.flags    = pend_m[d] ? FlIdle : FlIdleRdy;
            e.chk_addr = 1'b0;
            e.addr     = 8'd0;
            e.wp       = 8'(wp_m[d]);
         end else begin
            e = sched[d][0];
         end
         check_eq($sformatf("d%0d.flags@%0d", d, cyc), 32'(obs_flags(d)), 32'(e.flags));
         check_eq($sformatf("d%0d.wrPtr@%0d", d, cyc), 32'(obs_wp(d)), 32'(e.wp));
         if (e.chk_addr) begin
            check_eq($sformatf("d%0d.tapAddr@%0d", d, cyc), 32'(obs_addr(d)), 32'(e.addr));
         end
      end
      inValid = v;
      adaptEn = a;
      flush   = f;
      for (int d = 0; d < 2; d++) begin
         if (sched[d].size() != 0) begin
            void'(sched[d].pop_front());
            if (f) pend_m[d] = 1'b1;
         end else begin
            model_decide(d, v, a, f);
         end
      end
   endtask

   task automatic check_zero(input string tag);
      for (int d = 0; d < 2; d++) begin
         check_eq($sformatf("d%0d.%s.flags", d, tag), 32'(obs_flags(d)), 32'd0);
         check_eq($sformatf("d%0d.%s.tapAddr", d, tag), 32'(obs_addr(d)), 32'd0);
         check_eq($sformatf("d%0d.%s.wrPtr", d, tag), 32'(obs_wp(d)), 32'd0);
      end
   endtask

   task automatic do_reset(input bit immediate);
      inValid = 1'b0;
      adaptEn = 1'b0;
      flush   = 1'b0;
      if (immediate) begin
         #2;
         rst = 1'b1;
         #1;
         check_zero("rst_async");
      end else begin
         rst = 1'b1;
      end
      repeat (2) @(negedge clk);
      check_zero("rst_hold");
      rst = 1'b0;
      for (int d = 0; d < 2; d++) begin
         sched[d].delete();
         wp_m[d]   = 0;
         pend_m[d] = 1'b0;
      end
   endtask

   task automatic wait_idle();
      int guard;
      guard = 0;
      while ((sched[0].size() + sched[1].size()) != 0 && guard < 2000) begin
         step(1'b0, 1'b0, 1'b0);
         guard++;
      end
      check_eq("wait_idle", 32'(sched[0].size() + sched[1].size()), 32'd0);
   endtask

   initial begin
      int guard;
      tap_m[0] = 63;
      tap_m[1] = 4;
      do_reset(1'b0);

      // Single sample, no adaptation.
      step(1'b1, 1'b0, 1'b0);
      wait_idle();

      // Back-to-back samples with adaptation.
      repeat (60) step(1'b1, 1'b1, 1'b0);
      wait_idle();

      // Flush and inValid together while idle.
      step(1'b1, 1'b0, 1'b1);
      repeat (150) step(1'b1, 1'b0, 1'b0);
      wait_idle();

      // Flush while filtering an adapting sample.
      step(1'b1, 1'b1, 1'b0);
      repeat (10) step(1'b0, 1'b0, 1'b0);
      step(1'b0, 1'b0, 1'b1);
      wait_idle();

      // adaptEn changes after accept must not matter.
      step(1'b1, 1'b0, 1'b0);
      repeat (20) step(1'b0, 1'b1, 1'b0);
      wait_idle();
      step(1'b1, 1'b1, 1'b0);
      repeat (20) step(1'b0, 1'b0, 1'b0);
      wait_idle();

      // Randomised traffic.
      repeat (4000) begin
         step($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1, $urandom_range(0, 99) == 0);
      end
      wait_idle();

      // Reset in the middle of a coefficient update.
      guard = 0;
      while (!(sched[0].size() != 0 && sched[0][0].flags == FlUpd) && guard < 1000) begin
         step(1'b1, 1'b1, 1'b0);
         guard++;
      end
      check_eq("reach_upd", 32'(sched[0].size() != 0 && sched[0][0].flags == FlUpd), 32'd1);
      repeat (3) step(1'b0, 1'b0, 1'b0);
      do_reset(1'b1);
      repeat (200) step(1'b0, 1'b0, 1'b0);
      step(1'b1, 1'b1, 1'b0);
      wait_idle();

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
